// File: rtl/board_seeder.sv
// rtl/board_seeder.sv - fills the Game of Life board with random cells from a 32-bit PRNG
module board_seeder #(
    parameter int ROWS   = 32,
    parameter int COLS   = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [8:0]        density,
    output logic              busy,
    output logic              done,
    output logic              rand_en,
    input  logic [31:0]       rand_in,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_data
);

    localparam int CELLS = ROWS * COLS;
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        CAPT,
        EMIT,
        FIN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cell_cnt;
    logic [1:0]        lane;
    logic [31:0]       word_buf;
    logic [8:0]        dens_q;
    logic [7:0]        lane_byte;
    logic              cell_alive;
    logic              start_ok;
    logic              wr_fire;

    // Current byte lane of the captured word and its alive decision (9-bit compare so 256 means always alive)
    always_comb begin
        lane_byte  = word_buf[{lane, 3'b000} +: 8];
        cell_alive = ({1'b0, lane_byte} < dens_q);
        start_ok   = (state == IDLE) && start && !abort;
        wr_fire    = (state == EMIT) && wr_ready;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and outputs; abort overrides everything outside IDLE
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == FIN);
        rand_en   = (state == DRAW);
        wr_valid  = (state == EMIT);
        wr_addr   = '0;
        wr_data   = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = DRAW;
                end
            end
            DRAW: state_nxt = CAPT;
            CAPT: state_nxt = EMIT;
            EMIT: begin
                wr_addr = cell_cnt;
                wr_data = cell_alive;
                if (wr_ready) begin
                    if (cell_cnt == LAST_CELL) begin
                        state_nxt = FIN;
                    end else if (lane == 2'd3) begin
                        state_nxt = DRAW;
                    end
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
        end
    end

    // Datapath: density latch, word capture, lane and cell counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cell_cnt <= '0;
            lane     <= 2'd0;
            word_buf <= 32'd0;
            dens_q   <= 9'd0;
        end else begin
            if (start_ok) begin
                dens_q   <= density;
                cell_cnt <= '0;
            end
            if (state == CAPT) begin
                word_buf <= rand_in;
                lane     <= 2'd0;
            end
            if (wr_fire) begin
                cell_cnt <= cell_cnt + ADDR_W'(1);
                lane     <= lane + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_board_seeder.sv
// tb/tb_board_seeder.sv - randomized self-checking bench for board_seeder (4x4 and 3x3 boards)
module tb_board_seeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        wr_ready = 1'b0;
    logic        sel = 1'b0;
    logic [8:0]  density = 9'd0;
    logic [31:0] rand_in = 32'd0;

    logic       b4, d4, re4, v4, wd4;
    logic [3:0] a4;
    logic       b3, d3, re3, v3, wd3;
    logic [3:0] a3;

    logic       busy, done, rand_en, wr_valid, wr_data;
    logic [3:0] wr_addr;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] words[$];

    always #5 clk = ~clk;

    board_seeder #(.ROWS(4), .COLS(4), .ADDR_W(4)) u_b4 (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .abort(abort & ~sel),
        .density(density), .busy(b4), .done(d4), .rand_en(re4), .rand_in(rand_in),
        .wr_valid(v4), .wr_ready(wr_ready), .wr_addr(a4), .wr_data(wd4)
    );

    board_seeder #(.ROWS(3), .COLS(3), .ADDR_W(4)) u_b3 (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .abort(abort & sel),
        .density(density), .busy(b3), .done(d3), .rand_en(re3), .rand_in(rand_in),
        .wr_valid(v3), .wr_ready(wr_ready), .wr_addr(a3), .wr_data(wd3)
    );

    assign busy     = sel ? b3  : b4;
    assign done     = sel ? d3  : d4;
    assign rand_en  = sel ? re3 : re4;
    assign wr_valid = sel ? v3  : v4;
    assign wr_data  = sel ? wd3 : wd4;
    assign wr_addr  = sel ? a3  : a4;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: cell idx comes from byte (idx mod 4) of the (idx div 4)-th drawn word
    function automatic logic exp_cell(input int idx, input logic [8:0] d);
        logic [31:0] w;
        int          b;
        w = words[idx / 4];
        b = int'((w >> (8 * (idx % 4))) & 32'hFF);
        return (b < int'(d));
    endfunction

    task automatic run(input bit s, input logic [8:0] d, input int pct, input bit rnd, input int abort_at);
        int   cells;
        int   nwords;
        int   idx = 0;
        int   n_re = 0;
        int   n_done = 0;
        int   cyc = 0;
        int   done_cyc = -1;
        int   last_hs = -10;
        bit   pend = 0;
        bit   stalled = 0;
        bit   fin = 0;
        bit   aborted = 0;
        bit   abort_next = 0;
        logic [3:0] h_addr = '0;
        logic h_data = 1'b0;
        logic e;
        cells  = s ? 9 : 16;
        nwords = (cells + 3) / 4;
        sel    = s;
        abort  = 1'b0;
        words.delete();
        @(posedge clk); #1;
        density = d;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        density = 9'($urandom_range(0, 256));
        cyc     = 1;
        chk("busy_after_start", busy, 1);
        while (!fin && cyc < 3000) begin
            if (pend) begin
                rand_in = rnd ? $urandom : 32'h807F_00FF;
                words.push_back(rand_in);
                pend = 0;
            end
            wr_ready = ($urandom_range(0, 99) < pct);
            abort    = 1'b0;
            if (abort_next) begin
                abort      = 1'b1;
                wr_ready   = 1'b0;
                abort_next = 0;
                aborted    = 1;
            end
            if (rand_en) begin
                n_re++;
                pend = 1;
            end
            if (stalled && wr_valid) begin
                chk("hold_addr", wr_addr, h_addr);
                chk("hold_data", wr_data, h_data);
            end
            stalled = 0;
            if (wr_valid) begin
                if (wr_ready) begin
                    e = (idx / 4 < words.size()) ? exp_cell(idx, d) : ~wr_data;
                    chk("addr", wr_addr, idx);
                    chk("data", wr_data, e);
                    if (idx == abort_at) abort_next = 1;
                    idx++;
                    last_hs = cyc;
                end else begin
                    stalled = 1;
                    h_addr  = wr_addr;
                    h_data  = wr_data;
                end
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
                chk("done_writes", idx, cells);
                chk("done_latency", cyc - last_hs, 1);
            end
            @(posedge clk); #1;
            cyc++;
            if (aborted) begin
                chk("abort_busy", busy, 0);
                chk("abort_valid", wr_valid, 0);
                chk("abort_done", done, 0);
                fin = 1;
            end else if (done_cyc >= 0) begin
                chk("busy_after_done", busy, 0);
                fin = 1;
            end
        end
        abort    = 1'b0;
        wr_ready = 1'b0;
        if (!fin) chk("timeout", 0, 1);
        if (!aborted) begin
            chk("write_count", idx, cells);
            chk("rand_en_count", n_re, nwords);
            chk("done_count", n_done, 1);
            if (pct == 100)
                chk("done_cycle", done_cyc, 6 * (nwords - 1) + 2 + (cells - 4 * (nwords - 1)) + 1);
        end
        @(posedge clk); #1;
        chk("idle_quiet", {rand_en, wr_valid, busy, done}, 0);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rand_en"}, rand_en, 0);
        chk({tag, "_valid"}, wr_valid, 0);
        chk({tag, "_addr"}, wr_addr, 0);
        chk({tag, "_data"}, wr_data, 0);
    endtask

    initial begin
        int guard;
        #2;
        reset_check("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        run(0, 9'd128, 100, 0, -1);
        run(0, 9'd0,   100, 0, -1);
        run(0, 9'd256, 100, 0, -1);
        run(0, 9'($urandom_range(0, 256)), 30, 1, -1);
        run(1, 9'($urandom_range(0, 256)), 100, 1, -1);
        run(1, 9'($urandom_range(0, 256)), 50, 1, -1);
        run(0, 9'd200, 100, 1, 5);
        run(0, 9'd60, 70, 1, -1);

        sel      = 1'b0;
        density  = 9'd256;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        wr_ready = 1'b0;
        guard    = 0;
        while (!wr_valid && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("pre_reset_valid", wr_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        reset_check("async_reset");
        start = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("start_in_reset", busy, 0);
        end
        start = 1'b0;
        #3;
        rst_n = 1'b1;
        run(0, 9'd128, 100, 0, -1);

        for (int k = 0; k < 4; k++)
            run(k[0], 9'($urandom_range(0, 256)), $urandom_range(20, 100), 1, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
